// File: rtl/aes_pkg.sv
// Shared AES constants, state/FSM types and the FIPS-197 forward S-box table
// (also consumed by the key-expansion SubWord).
package aes_pkg;

    localparam int unsigned Nb        = 128;
    localparam int unsigned BYTE      = 8;
    localparam int unsigned NUM_BYTES = Nb / BYTE;

    typedef logic [Nb-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box: one byte in, its substitution out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE-1:0] i_byte,
    output logic [BYTE-1:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes per cycle through shared
// S-boxes, lowest bytes first, and holds the result for ShiftRows.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [Nb-1:0] s,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [Nb-1:0] s_tab,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned STEPS = NUM_BYTES / LANES;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_BYTES);
    localparam int unsigned SEL_W = $clog2(BYTE);

    if ((LANES == 0) || ((NUM_BYTES % LANES) != 0)) begin : g_bad_lanes
        $error("LANES must divide %0d", NUM_BYTES);
    end

    fsm_e             r_state;
    logic [CW-1:0]    r_cnt;
    state_t           r_work;
    logic             r_idle;
    logic             r_out_valid;

    logic [IDX_W-1:0] w_base;
    logic             w_last;
    logic [BYTE-1:0]  w_lane_in  [LANES];
    logic [BYTE-1:0]  w_lane_out [LANES];

    // Byte index of lane 0 for the current step.
    assign w_base = IDX_W'(r_cnt) * IDX_W'(LANES);
    assign w_last = (r_cnt == CW'(STEPS - 1));

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign w_lane_in[l] = r_work[{w_base + IDX_W'(l), {SEL_W{1'b0}}} +: BYTE];

        aes_sbox u_sbox (
            .i_byte (w_lane_in[l]),
            .o_byte (w_lane_out[l])
        );
    end

    // Ready in DONE follows out_ready so a new state can enter on the same
    // edge the result leaves.
    assign in_ready  = r_idle | (r_out_valid & out_ready);
    assign out_valid = r_out_valid;
    assign s_tab     = r_work;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_idle      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= s;
                        r_cnt   <= '0;
                        r_idle  <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < int'(LANES); l++) begin
                        r_work[{w_base + IDX_W'(l), {SEL_W{1'b0}}} +: BYTE] <= w_lane_out[l];
                    end
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_work  <= s;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_idle  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_idle      <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
